// File: rtl/encoder_istruzioni_if.sv
// Field/handshake bundle between an instruction producer and the encoder,
// plus the instruction-memory write port and status the encoder drives back.
interface encoder_istruzioni_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        kind;
  logic [3:0]        cond;
  logic [3:0]        cmd;
  logic              imm;
  logic              setf;
  logic [3:0]        rn;
  logic [3:0]        rd;
  logic [11:0]       src2;
  logic [23:0]       offset;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, kind, cond, cmd, imm, setf, rn, rd, src2, offset,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  in_valid, kind, cond, cmd, imm, setf, rn, rd, src2, offset,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/encoder_istruzioni.sv
// Packs instruction fields into 32-bit words and writes them sequentially
// into an instruction memory until it is full; illegal classes pulse err.
module encoder_istruzioni #(
  parameter int ADDR_W = 6
) (
  input logic                clk,
  input logic                reset_n,
  input logic                clear,
  encoder_istruzioni_if.slave bus
);

  typedef enum logic {LOAD, FULL} state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   count_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              err_q;
  logic              in_ready;
  logic              handshake;
  logic              legal;
  logic [31:0]       word;

  assign in_ready  = (state_q == LOAD) && !clear && reset_n;
  assign handshake = bus.in_valid && in_ready;
  assign legal     = (bus.kind != 2'b11);

  always_comb begin
    word = 32'h0;
    case (bus.kind)
      2'b00:   word = {bus.cond, 2'b00, bus.imm, bus.cmd, bus.setf,
                       bus.rn, bus.rd, bus.src2};
      2'b01:   word = {bus.cond, 2'b01, bus.imm, 1'b1, 1'b1, 1'b0, 1'b0,
                       bus.setf, bus.rn, bus.rd, bus.src2};
      2'b10:   word = {bus.cond, 3'b101, 1'b0, bus.offset};
      default: word = 32'h0;
    endcase
  end

  // FULL is entered on the write that brings count to the memory depth
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else if (state_q == LOAD && handshake && legal && count_q == LAST) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear keeps the last address/word visible; only reset zeroes them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr        <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      count_q  <= '0;
      mem_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      err_q    <= 1'b0;
      if (handshake) begin
        if (legal) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= wptr;
          mem_wdata_q <= word;
          wptr        <= wptr + ADDR_W'(1);
          count_q     <= count_q + (ADDR_W+1)'(1);
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = (state_q == FULL);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_encoder_istruzioni.sv
// Directed bench for encoder_istruzioni with a 4-deep memory: encodings,
// fill to full, illegal class, clear in FULL and reset mid-stream.
module tb_encoder_istruzioni;

  logic clk;
  logic reset_n;
  logic clear;
  int   tests;
  int   failed;

  encoder_istruzioni_if #(.ADDR_W(2)) bus ();

  encoder_istruzioni #(.ADDR_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [1:0] kind,
                               input logic [3:0] cond, input logic [3:0] cmd,
                               input logic imm, input logic setf,
                               input logic [3:0] rn, input logic [3:0] rd,
                               input logic [11:0] src2, input logic [23:0] offset);
    bus.in_valid = valid;
    bus.kind     = kind;
    bus.cond     = cond;
    bus.cmd      = cmd;
    bus.imm      = imm;
    bus.setf     = setf;
    bus.rn       = rn;
    bus.rd       = rd;
    bus.src2     = src2;
    bus.offset   = offset;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyDp();
    applyStimulus(1'b1, 2'b00, 4'hE, 4'h4, 1'b1, 1'b0, 4'h1, 4'h2, 12'h005, 24'h0);
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 24'h0);
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    reset_n = 1'b0;
    clear   = 1'b0;
    applyIdle();
    bus.in_valid = 1'b1;

    // Reset state, with in_valid asserted to show it is ignored
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_mem_we",   32'(bus.mem_we),   32'd0);
    checkOutput("rst_count",    32'(bus.count),    32'd0);
    checkOutput("rst_wdata",    bus.mem_wdata,     32'h0);
    checkOutput("rst_err",      32'(bus.err),      32'd0);
    checkOutput("rst_full",     32'(bus.full),     32'd0);
    reset_n = 1'b1;
    applyIdle();
    #1 checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Single data-processing word, then hold with mem_we low
    @(negedge clk); applyDp();
    @(negedge clk); applyIdle();
    checkOutput("dp_mem_we", 32'(bus.mem_we),   32'd1);
    checkOutput("dp_addr",   32'(bus.mem_addr), 32'd0);
    checkOutput("dp_wdata",  bus.mem_wdata,     32'hE2812005);
    checkOutput("dp_count",  32'(bus.count),    32'd1);
    @(negedge clk);
    checkOutput("hold_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("hold_wdata",  bus.mem_wdata,   32'hE2812005);

    // Illegal class: err pulse only
    applyStimulus(1'b1, 2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 24'h0);
    @(negedge clk); applyIdle();
    checkOutput("ill_err",    32'(bus.err),    32'd1);
    checkOutput("ill_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("ill_count",  32'(bus.count),  32'd1);
    @(negedge clk);
    checkOutput("ill_err_drop", 32'(bus.err), 32'd0);

    // Clear restarts the pointer
    clear = 1'b1;
    #1 checkOutput("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); clear = 1'b0;
    checkOutput("clr_count", 32'(bus.count), 32'd0);

    // Four back-to-back writes fill the memory
    applyDp();
    @(negedge clk);
    checkOutput("fill0_addr",  32'(bus.mem_addr), 32'd0);
    checkOutput("fill0_wdata", bus.mem_wdata,     32'hE2812005);
    applyStimulus(1'b1, 2'b01, 4'hE, 4'h0, 1'b1, 1'b1, 4'h0, 4'h3, 12'h004, 24'h0);
    @(negedge clk);
    checkOutput("fill1_we",    32'(bus.mem_we),   32'd1);
    checkOutput("fill1_addr",  32'(bus.mem_addr), 32'd1);
    checkOutput("ldr_wdata",   bus.mem_wdata,     32'hE7903004);
    applyStimulus(1'b1, 2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 4'h0, 4'h3, 12'h004, 24'h0);
    @(negedge clk);
    checkOutput("fill2_addr",  32'(bus.mem_addr), 32'd2);
    checkOutput("str_wdata",   bus.mem_wdata,     32'hE7803004);
    checkOutput("fill2_count", 32'(bus.count),    32'd3);
    applyStimulus(1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 24'hFFFFFE);
    @(negedge clk);
    applyDp();
    checkOutput("fill3_addr",  32'(bus.mem_addr), 32'd3);
    checkOutput("b_wdata",     bus.mem_wdata,     32'h0AFFFFFE);
    checkOutput("fill3_count", 32'(bus.count),    32'd4);
    checkOutput("fill3_full",  32'(bus.full),     32'd1);
    checkOutput("fill3_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("full_no_we",  32'(bus.mem_we),   32'd0);
    checkOutput("full_count",  32'(bus.count),    32'd4);
    checkOutput("full_addr",   32'(bus.mem_addr), 32'd3);

    // Clear while full and in_valid high: no write, back to LOAD
    clear = 1'b1;
    #1 checkOutput("clrfull_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); clear = 1'b0; applyIdle();
    checkOutput("clrfull_count", 32'(bus.count),  32'd0);
    checkOutput("clrfull_full",  32'(bus.full),   32'd0);
    checkOutput("clrfull_we",    32'(bus.mem_we), 32'd0);
    #1 checkOutput("clrfull_ready2", 32'(bus.in_ready), 32'd1);

    // Reset asserted the cycle after a handshake
    @(negedge clk); applyDp();
    @(negedge clk); applyIdle(); reset_n = 1'b0;
    checkOutput("mid_we_pre", 32'(bus.mem_we), 32'd1);
    #1 checkOutput("mid_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("mid_we",    32'(bus.mem_we), 32'd0);
    checkOutput("mid_count", 32'(bus.count),  32'd0);
    checkOutput("mid_wdata", bus.mem_wdata,   32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
